bch_chien_sched: RTL and testbench

//  Shares one bch_chien search unit between NREQ error-locator solvers.

---
 rtl/bch_chien_sched.sv | 181 ++++++++++++++++++
 tb/tb_bch_chien_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_chien_sched.sv
// Shares one Chien search unit between NREQ sigma solvers with round-robin grant.
// Ports: req_valid/req_sigma/req_ready from solvers; chien_* to/from the Chien unit;
//   root from the root detector; busy/owner/done/err_count/fail report the run.
//   Define BCH_CHIEN_SCHED_STATS_EN to add stat_runs/stat_fail counters.
module bch_chien_sched #(
  parameter int M    = 8,
  parameter int T    = 4,
  parameter int SZ   = (T + 1) * M,
  parameter int NREQ = 2,
  parameter int BITS = 1,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW  = $clog2(T + 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*SZ-1:0] req_sigma,
  output logic [NREQ-1:0]  req_ready,
  output logic             chien_start,
  output logic [SZ-1:0]    chien_sigma,
  input  logic             chien_ready,
  input  logic             chien_valid,
  input  logic             chien_last,
  input  logic [BITS-1:0]  root,
  output logic             busy,
  output logic [IDW-1:0]   owner,
  output logic             done,
  output logic [CW-1:0]    err_count,
`ifdef BCH_CHIEN_SCHED_STATS_EN
  output logic [31:0]      stat_runs,
  output logic [31:0]      stat_fail,
`endif
  output logic             fail
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [SZ-1:0]   sigma_q, sigma_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   err_q, err_d;
  logic            fail_q, fail_d;

  logic            gnt_any;
  int              gnt_idx;
  int              idx;
  int              pop;
  int              sum;
  logic            can_grant;

  // Scan downward from the farthest offset so the lowest offset
  // from the rr pointer is the last (winning) assignment.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 0;
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  // Root count for this beat, saturating at T+1.
  always_comb begin
    pop = 0;
    for (int b = 0; b < BITS; b++) begin
      pop = pop + int'(root[b]);
    end
    sum = int'(count_q) + pop;
    if (sum > T + 1) begin
      sum = T + 1;
    end
  end

  assign can_grant = (state_q == IDLE || state_q == DONE)
                   && chien_ready && gnt_any;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    sigma_d   = sigma_q;
    count_d   = count_q;
    err_d     = err_q;
    fail_d    = fail_q;
    req_ready = '0;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (can_grant) begin
          req_ready = NREQ'(1) << gnt_idx;
          sigma_d   = req_sigma[gnt_idx*SZ +: SZ];
          owner_d   = IDW'(gnt_idx);
          count_d   = '0;
          rr_d      = IDW'((gnt_idx + 1) % NREQ);
          state_d   = START;
        end
      end
      START: state_d = RUN;
      RUN: begin
        if (chien_valid) begin
          count_d = CW'(sum);
          if (chien_last) begin
            err_d   = CW'(sum);
            fail_d  = (sum > T);
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      sigma_q <= '0;
      count_q <= '0;
      err_q   <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      sigma_q <= sigma_d;
      count_q <= count_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign chien_start = (state_q == START);
  assign chien_sigma = sigma_q;
  assign owner       = owner_q;
  assign err_count   = err_q;
  assign fail        = fail_q;

`ifdef BCH_CHIEN_SCHED_STATS_EN
  logic [31:0] runs_q, runs_d;
  logic [31:0] fails_q, fails_d;

  always_comb begin
    runs_d  = runs_q;
    fails_d = fails_q;
    if (state_q == DONE) begin
      runs_d = runs_q + 32'd1;
      if (fail_q) begin
        fails_d = fails_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      runs_q  <= '0;
      fails_q <= '0;
    end else begin
      runs_q  <= runs_d;
      fails_q <= fails_d;
    end
  end

  assign stat_runs = runs_q;
  assign stat_fail = fails_q;
`endif

endmodule

// File: tb/tb_bch_chien_sched.sv
// Directed bench for bch_chien_sched: two instances (NREQ=2/BITS=1 and
// NREQ=1/BITS=2), checked with immediate assertions against hand-computed values.
module tb_bch_chien_sched;

  localparam int T  = 4;
  localparam int M  = 4;
  localparam int SZ = (T + 1) * M;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // instance A: two requesters, one root bit
  logic [1:0]      a_req_valid;
  logic [2*SZ-1:0] a_req_sigma;
  logic [1:0]      a_req_ready;
  logic            a_start;
  logic [SZ-1:0]   a_sigma;
  logic            a_cready, a_cvalid, a_clast;
  logic [0:0]      a_root;
  logic            a_busy, a_done, a_fail;
  logic [0:0]      a_owner;
  logic [2:0]      a_err;
`ifdef BCH_CHIEN_SCHED_STATS_EN
  logic [31:0]     a_runs, a_sfail;
  logic [31:0]     b_runs, b_sfail;
`endif

  // instance B: one requester, two root bits
  logic [0:0]      b_req_valid;
  logic [SZ-1:0]   b_req_sigma;
  logic [0:0]      b_req_ready;
  logic            b_start;
  logic [SZ-1:0]   b_sigma;
  logic            b_cready, b_cvalid, b_clast;
  logic [1:0]      b_root;
  logic            b_busy, b_done, b_fail;
  logic [0:0]      b_owner;
  logic [2:0]      b_err;

  int n_cmp = 0;
  int n_bad = 0;

  bch_chien_sched #(.M(M), .T(T), .SZ(SZ), .NREQ(2), .BITS(1)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_sigma(a_req_sigma),
    .req_ready(a_req_ready), .chien_start(a_start),
    .chien_sigma(a_sigma), .chien_ready(a_cready),
    .chien_valid(a_cvalid), .chien_last(a_clast),
    .root(a_root), .busy(a_busy), .owner(a_owner),
    .done(a_done), .err_count(a_err),
`ifdef BCH_CHIEN_SCHED_STATS_EN
    .stat_runs(a_runs), .stat_fail(a_sfail),
`endif
    .fail(a_fail)
  );

  bch_chien_sched #(.M(M), .T(T), .SZ(SZ), .NREQ(1), .BITS(2)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_sigma(b_req_sigma),
    .req_ready(b_req_ready), .chien_start(b_start),
    .chien_sigma(b_sigma), .chien_ready(b_cready),
    .chien_valid(b_cvalid), .chien_last(b_clast),
    .root(b_root), .busy(b_busy), .owner(b_owner),
    .done(b_done), .err_count(b_err),
`ifdef BCH_CHIEN_SCHED_STATS_EN
    .stat_runs(b_runs), .stat_fail(b_sfail),
`endif
    .fail(b_fail)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in START; ends in DONE. One idle RUN cycle with a stray
  // root (must be ignored), then n valid beats with roots[i].
  task automatic feed_a(input int n, input logic [15:0] roots);
    tick();
    chk("a_rdy_run", a_req_ready, 0);
    a_root   = 1'b1;
    a_cvalid = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      a_cvalid = 1'b1;
      a_root   = roots[i];
      a_clast  = (i == n - 1);
      tick();
    end
    a_cvalid = 1'b0;
    a_clast  = 1'b0;
    a_root   = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    a_req_valid = '0;
    a_req_sigma = {20'h12345, 20'hABCDE};
    a_cready    = 1'b1;
    a_cvalid    = 1'b0;
    a_clast     = 1'b0;
    a_root      = '0;
    b_req_valid = '0;
    b_req_sigma = 20'h5A5A5;
    b_cready    = 1'b1;
    b_cvalid    = 1'b0;
    b_clast     = 1'b0;
    b_root      = '0;
    tick();
    tick();
    chk("rst_busy", a_busy, 0);
    chk("rst_owner", a_owner, 0);
    chk("rst_done", a_done, 0);
    chk("rst_err", a_err, 0);
    chk("rst_fail", a_fail, 0);
    chk("rst_sigma", a_sigma, 0);
    chk("rst_start", a_start, 0);
    reset = 1'b0;
    tick();

    // single request, two roots
    a_req_valid = 2'b01;
    #1;
    chk("t1_ready", a_req_ready, 2'b01);
    tick();
    a_req_valid = 2'b00;
    chk("t1_start", a_start, 1);
    chk("t1_sigma", a_sigma, 20'hABCDE);
    chk("t1_busy", a_busy, 1);
    feed_a(3, 16'b101);
    chk("t1_done", a_done, 1);
    chk("t1_err", a_err, 2);
    chk("t1_fail", a_fail, 0);
    chk("t1_owner", a_owner, 0);
    tick();
    chk("t1_idle_done", a_done, 0);
    chk("t1_idle_busy", a_busy, 0);
    chk("t1_err_hold", a_err, 2);

    // both held: back-to-back alternating grants
    pulse_reset();
    a_req_valid = 2'b11;
    #1;
    chk("t2_ready0", a_req_ready, 2'b01);
    tick();
    chk("t2_start0", a_start, 1);
    chk("t2_owner0", a_owner, 0);
    feed_a(1, 16'b0);
    chk("t2_done0", a_done, 1);
    chk("t2_downer0", a_owner, 0);
    chk("t2_ready1", a_req_ready, 2'b10);
    tick();
    chk("t2_start1", a_start, 1);
    chk("t2_owner1", a_owner, 1);
    chk("t2_sigma1", a_sigma, 20'h12345);
    feed_a(1, 16'b1);
    chk("t2_done1", a_done, 1);
    chk("t2_downer1", a_owner, 1);
    chk("t2_err1", a_err, 1);
    chk("t2_ready2", a_req_ready, 2'b01);
    tick();
    chk("t2_start2", a_start, 1);
    chk("t2_owner2", a_owner, 0);
    a_req_valid = 2'b00;
    feed_a(1, 16'b0);
    tick();
    chk("t2_idle", a_busy, 0);

    // saturation: six roots with T=4
    pulse_reset();
    a_req_valid = 2'b01;
    tick();
    a_req_valid = 2'b00;
    feed_a(6, 16'h003F);
    chk("t3_done", a_done, 1);
    chk("t3_err", a_err, 5);
    chk("t3_fail", a_fail, 1);
    tick();
    chk("t3_fail_hold", a_fail, 1);

    // reset mid-run, chien_ready low blocks grants
    a_req_valid = 2'b01;
    tick();
    a_req_valid = 2'b00;
    tick();
    chk("t5_inrun", a_busy, 1);
    reset = 1'b1;
    #1;
    chk("t5_rst_busy", a_busy, 0);
    chk("t5_rst_sigma", a_sigma, 0);
    chk("t5_rst_fail", a_fail, 0);
    a_cready    = 1'b0;
    a_req_valid = 2'b01;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t5_noready", a_req_ready, 0);
      tick();
      chk("t5_nostart", a_start, 0);
      chk("t5_nobusy", a_busy, 0);
    end
    a_cready = 1'b1;
    #1;
    chk("t5_ready", a_req_ready, 2'b01);
    tick();
    a_req_valid = 2'b00;
    chk("t5_start", a_start, 1);

    // zero roots, last on first valid beat
    feed_a(1, 16'b0);
    chk("t6_done", a_done, 1);
    chk("t6_err", a_err, 0);
    chk("t6_fail", a_fail, 0);
`ifdef BCH_CHIEN_SCHED_STATS_EN
    chk("t6_runs_pre", a_runs, 0);
    tick();
    chk("t6_runs", a_runs, 1);
    chk("t6_sfail", a_sfail, 0);
`else
    tick();
`endif

    // BITS=2 instance: 2'b11 then 2'b01
    b_req_valid = 1'b1;
    #1;
    chk("t4_ready", b_req_ready, 1);
    tick();
    b_req_valid = 1'b0;
    chk("t4_start", b_start, 1);
    chk("t4_sigma", b_sigma, 20'h5A5A5);
    tick();
    b_cvalid = 1'b1;
    b_root   = 2'b11;
    tick();
    b_root   = 2'b01;
    b_clast  = 1'b1;
    tick();
    b_cvalid = 1'b0;
    b_clast  = 1'b0;
    b_root   = 2'b00;
    chk("t4_done", b_done, 1);
    chk("t4_err", b_err, 3);
    chk("t4_fail", b_fail, 0);
    chk("t4_owner", b_owner, 0);
    tick();
    chk("t4_idle", b_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
